riscv_muldiv_unit: RTL
======================

// Module: riscv_muldiv_unit
// PURPOSE
//   Iterative RV32M/RV64M multiply/divide unit for the EX stage of the 5-stage pipeline.
//   Accepts one M-extension op via valid/ready, computes one bit per cycle (shift-add / restoring),
//   returns result + rd tag via valid/ready. Hazard unit holds StallF/StallD/StallE while busy_o=1;
//   flush_i (PCSrcE redirect) aborts an op in flight.
// PARAMETERS
//   XLEN   32  operand/result width (32 or 64)
//   TAG_W  5   destination-register tag width carried with the op
// PORTS
//   clk_i     in   1      clock, rising edge
//   rst_i     in   1      synchronous reset, active-high
//   flush_i   in   1      abort current op; dominates valid_i and ready_i
//   valid_i   in   1      op request
//   ready_o   out  1      unit can accept (state IDLE)
//   op_i      in   3      funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rs1_i     in   XLEN   operand A / dividend
//   rs2_i     in   XLEN   operand B / divisor
//   tag_i     in   TAG_W  rd of the op
//   valid_o   out  1      result available (state DONE)
//   ready_i   in   1      consumer (MEM stage) takes result
//   result_o  out  XLEN   result
//   tag_o     out  TAG_W  rd of result
//   busy_o    out  1      state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, tag_o=0, counter=0.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: accept on valid_i&&ready_o&&!flush_i; latch op, operands, tag; capture |operand| and sign
//     flags (signed per op: MULH both, MULHSU rs1 only, DIV/REM both). Next state CALC, counter=XLEN.
//   Fast path at accept -> DONE directly (valid_o 1 cycle after accept):
//     divide by zero: DIV/DIVU -> all-ones; REM/REMU -> rs1.
//     signed overflow DIV/REM rs1=1<<(XLEN-1), rs2=all-ones: DIV -> rs1; REM -> 0.
//   CALC: one iteration per cycle, counter decrements; 2*XLEN-bit unsigned product or XLEN-bit
//     quotient/remainder. After XLEN CALC cycles, sign-correct (two's complement negate: product if
//     sign flags differ; quotient if dividend/divisor signs differ; remainder takes dividend sign),
//     select low (MUL) or high (MULH*) half; enter DONE.
//   Latency: valid_o rises exactly XLEN+1 cycles after accepting edge (33 for XLEN=32); fast path 1.
//   DONE: result_o/tag_o stable while valid_o=1; held until ready_i=1, then IDLE (ready_o=1 next cycle).
//     No accept in the same cycle as result handoff (ready_o=0 in DONE): back-to-back throughput
//     one op per XLEN+2 cycles.
//   flush_i=1 in any state: next state IDLE, valid_o=0 next cycle, op discarded, result_o retains old
//     value; flush_i together with valid_i in IDLE: op not accepted.
//   rst_i mid-operation: identical to reset values next cycle; op lost.
//   Input changes during CALC/DONE are ignored (operands latched at accept).
//   All arithmetic mod 2^XLEN; no exceptions, matching RISC-V spec.
// TESTING (XLEN=32)
//   MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, valid_o at cycle 33 after accept; MULH same -> 0xFFFFFFFF.
//   MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; tag 5'd12 -> tag_o 12.
//   DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//   DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0;
//     each valid_o 1 cycle after accept.
//   ready_i held 0 for 10 cycles in DONE -> result/tag stable, ready_o=0; ready_i=1 -> ready_o=1 next.
//   flush_i at CALC cycle 10 -> IDLE next cycle, valid_o never asserts; rst_i mid-CALC -> reset values.

Source files
------------

// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the EX-stage issue logic and the M-extension unit.
// flush_i and busy_o ride along so the hazard unit sees one connection.
interface riscv_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport slave (
    input  flush_i, valid_i, op_i, rs1_i, rs2_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, busy_o
  );

  modport master (
    output flush_i, valid_i, op_i, rs1_i, rs2_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: one shift-add or restoring-divide step per cycle
// on magnitudes, with sign correction folded into the final step.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  riscv_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_hi, r_lo, r_b;
  logic             r_neg_a, r_neg_b;
  logic [TAG_W-1:0] r_tag_op;
  logic             r_ready, r_valid, r_busy;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag;

  // Operand decode at accept
  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_div0, w_ovf;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_fast_res;

  always_comb begin
    w_is_div = bus.op_i[2];
    w_sgn_a  = (bus.op_i == 3'd1) || (bus.op_i == 3'd2) ||
               (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    w_sgn_b  = (bus.op_i == 3'd1) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    w_neg_a  = w_sgn_a && bus.rs1_i[XLEN-1];
    w_neg_b  = w_sgn_b && bus.rs2_i[XLEN-1];
    w_abs_a  = w_neg_a ? -bus.rs1_i : bus.rs1_i;
    w_abs_b  = w_neg_b ? -bus.rs2_i : bus.rs2_i;
    w_div0   = w_is_div && (bus.rs2_i == '0);
    w_ovf    = w_is_div && !bus.op_i[0] && (bus.rs1_i == SMIN) && (bus.rs2_i == '1);
    w_fast_res = '0;
    if (w_div0)     w_fast_res = bus.op_i[1] ? bus.rs1_i : '1;
    else if (w_ovf) w_fast_res = bus.op_i[1] ? '0 : bus.rs1_i;
  end

  // One iteration: {r_hi,r_lo} is the product register (mul) or {remainder,dividend/quotient} (div)
  logic [XLEN:0]     w_sum, w_rsh, w_diff;
  logic [XLEN-1:0]   w_hi_nx, w_lo_nx;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_final;

  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rsh  = {r_hi, r_lo[XLEN-1]};
    w_diff = w_rsh - {1'b0, r_b};
    if (!r_op[2]) begin
      w_hi_nx = w_sum[XLEN:1];
      w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    end else if (!w_diff[XLEN]) begin
      w_hi_nx = w_diff[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      w_hi_nx = w_rsh[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
    end
    w_prod   = {w_hi_nx, w_lo_nx};
    w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    w_quo_s  = (r_neg_a ^ r_neg_b) ? -w_lo_nx : w_lo_nx;
    w_rem_s  = r_neg_a ? -w_hi_nx : w_hi_nx;
    case (r_op)
      3'd0:       w_final = w_prod_s[XLEN-1:0];
      3'd4, 3'd5: w_final = w_quo_s;
      3'd6, 3'd7: w_final = w_rem_s;
      default:    w_final = w_prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_tag_op <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_tag    <= '0;
    end else if (bus.flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.valid_i) begin
          r_op     <= bus.op_i;
          r_hi     <= '0;
          r_lo     <= w_abs_a;
          r_b      <= w_abs_b;
          r_neg_a  <= w_neg_a;
          r_neg_b  <= w_neg_b;
          r_tag_op <= bus.tag_i;
          r_ready  <= 1'b0;
          r_busy   <= 1'b1;
          if (w_div0 || w_ovf) begin
            r_state  <= S_DONE;
            r_cnt    <= '0;
            r_valid  <= 1'b1;
            r_result <= w_fast_res;
            r_tag    <= bus.tag_i;
          end else begin
            r_state <= S_CALC;
            r_cnt   <= CW'(XLEN);
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt - 1'b1;
          // Last step also sign-corrects, so DONE lands XLEN cycles after CALC entry
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_valid  <= 1'b1;
            r_result <= w_final;
            r_tag    <= r_tag_op;
          end
        end
        S_DONE: if (bus.ready_i) begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.valid_o  = r_valid;
  assign bus.busy_o   = r_busy;
  assign bus.result_o = r_result;
  assign bus.tag_o    = r_tag;
endmodule
